// File: rtl/gameconsole_pkg.sv
// Shared console constants and the VRAM scheduler types.
package gameconsole_pkg;

  localparam int SCREEN_W      = 320;
  localparam int SCREEN_HBLANK = 80;
  localparam int SCREEN_H      = 240;
  localparam int SCREEN_VBLANK = 80;
  localparam int TILE_ADDR_W   = 15;
  localparam int TILE_DATA_W   = 8;

  localparam int H_TOTAL = SCREEN_W + SCREEN_HBLANK;
  localparam int V_TOTAL = SCREEN_H + SCREEN_VBLANK;

  typedef enum logic [1:0] {OWN_NONE, OWN_REN, OWN_CPU} vram_owner_t;
  typedef enum logic {SCHED_IDLE, SCHED_CPU_DONE} vram_sched_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters, blank decodes and the start-of-vblank pulse; shared with scan-out.
module video_timing_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_BLANK  = 80,
  parameter int V_ACTIVE = 240,
  parameter int V_BLANK  = 80
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hblank,
  output logic       vblank,
  output logic       vblank_irq
);
  localparam int HT = H_ACTIVE + H_BLANK;
  localparam int VT = V_ACTIVE + V_BLANK;

  logic h_wrap, v_wrap;
  assign h_wrap = (hcnt == 9'(HT - 1));
  assign v_wrap = (vcnt == 9'(VT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      vcnt       <= '0;
      vblank_irq <= 1'b0;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 9'd1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 9'd1;
      // Look one cycle ahead so the pulse lands exactly on hcnt==0, vcnt==V_ACTIVE.
      vblank_irq <= h_wrap && (vcnt == 9'(V_ACTIVE - 1));
    end
  end

  assign hblank = (hcnt >= 9'(H_ACTIVE));
  assign vblank = (vcnt >= 9'(V_ACTIVE));

endmodule

// File: rtl/ppu_vram_sched.sv
// Tile RAM arbiter: renderer always wins, CPU fills idle (optionally blank-only) cycles.
module ppu_vram_sched
  import gameconsole_pkg::*;
#(
  parameter int H_ACTIVE = SCREEN_W,
  parameter int H_BLANK  = SCREEN_HBLANK,
  parameter int V_ACTIVE = SCREEN_H,
  parameter int V_BLANK  = SCREEN_VBLANK,
  parameter int ADDR_W   = TILE_ADDR_W,
  parameter int DATA_W   = TILE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpu_blank_only,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_rvalid,
  output logic [DATA_W-1:0] ren_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [8:0]        hcnt,
  output logic [8:0]        vcnt,
  output logic              hblank,
  output logic              vblank,
  output logic              vblank_irq
);
  vram_sched_state_t state;
  vram_owner_t       owner;
  logic              cpu_rd_q;
  logic              blank_ok, ren_go, cpu_go;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK)
  ) u_timing (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .hblank(hblank), .vblank(vblank), .vblank_irq(vblank_irq)
  );

  // Issue is gated by rst so the RAM sees nothing while reset is held.
  assign blank_ok = !cfg_cpu_blank_only || hblank || vblank;
  assign ren_go   = !rst && ren_req;
  assign cpu_go   = !rst && !ren_req && (state == SCHED_IDLE) && cpu_req && blank_ok;

  always_comb begin
    mem_en    = ren_go || cpu_go;
    mem_we    = cpu_go && cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ren_go) begin
      mem_addr = ren_addr;
    end else if (cpu_go) begin
      mem_addr = cpu_addr;
      if (cpu_we) mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCHED_IDLE;
      owner    <= OWN_NONE;
      cpu_rd_q <= 1'b0;
    end else begin
      // CPU_DONE is the ack cycle and always falls back to IDLE.
      state    <= cpu_go ? SCHED_CPU_DONE : SCHED_IDLE;
      owner    <= ren_go ? OWN_REN : (cpu_go ? OWN_CPU : OWN_NONE);
      cpu_rd_q <= cpu_go && !cpu_we;
    end
  end

  assign ren_rvalid = !rst && (owner == OWN_REN);
  assign ren_rdata  = ren_rvalid ? mem_rdata : '0;
  assign cpu_ack    = !rst && (owner == OWN_CPU);
  assign cpu_rdata  = (cpu_ack && cpu_rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ppu_vram_sched.sv
// Directed bench for ppu_vram_sched with a behavioural 1-cycle-latency tile RAM.
module tb_ppu_vram_sched;
  localparam int HA = 320, HB = 80, VA = 24, VB = 8;
  localparam int HT = HA + HB, VT = VA + VB, FRAME = HT * VT;

  logic        clk, rst, cfg_cpu_blank_only;
  logic        ren_req, ren_rvalid, cpu_req, cpu_we, cpu_ack;
  logic [14:0] ren_addr, cpu_addr, mem_addr;
  logic [7:0]  ren_rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, hblank, vblank, vblank_irq;
  logic [8:0]  hcnt, vcnt;
  logic [7:0]  mem [0:32767];

  int n_chk = 0, n_err = 0;

  ppu_vram_sched #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .ADDR_W(15), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst), .cfg_cpu_blank_only(cfg_cpu_blank_only),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank), .vblank_irq(vblank_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] all_outs();
    return {ren_rvalid, ren_rdata, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
            hcnt, vcnt, hblank, vblank, vblank_irq};
  endfunction

  int eh, ev, nirq, vmax, first_hb, nw, nval;
  logic prev_ack;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'h3C;
    rst = 1'b1; cfg_cpu_blank_only = 1'b0;
    ren_req = 1'b0; ren_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state
    cyc(); cyc(); cyc(); #1;
    chk("reset_outs", all_outs(), 64'd0);

    // One full frame of raster timing
    rst = 1'b0;
    eh = 0; ev = 0; nirq = 0; vmax = 0; first_hb = -1;
    for (int i = 0; i <= FRAME; i++) begin
      #1;
      chk("frame", {43'd0, vcnt, hcnt, hblank, vblank, vblank_irq},
          {43'd0, 9'(ev), 9'(eh), eh >= HA, ev >= VA, (eh == 0) && (ev == VA)});
      if (vblank_irq) nirq++;
      if (int'(vcnt) > vmax) vmax = int'(vcnt);
      if (hblank && first_hb < 0) first_hb = int'(hcnt);
      if (i < FRAME) begin
        cyc();
        eh++;
        if (eh == HT) begin
          eh = 0; ev++;
          if (ev == VT) ev = 0;
        end
      end
    end
    chk("irq_count", 64'(nirq), 64'd1);
    chk("vcnt_max", 64'(vmax), 64'(VT - 1));
    chk("hblank_first", 64'(first_hb), 64'd320);

    // Blank-only CPU write requested mid-line
    cyc();
    for (int n = 0; n < 20000 && !(hcnt == 9'd100 && vcnt == 9'd10); n++) cyc();
    chk("bo_sync", {46'd0, vcnt, hcnt}, {46'd0, 9'd10, 9'd100});
    cfg_cpu_blank_only = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 8'h5A;
    #1;
    nw = 0;
    while (hcnt != 9'd320 && nw < 400) begin
      chk("bo_hold", {62'd0, mem_en, cpu_ack}, 64'd0);
      cyc(); #1; nw++;
    end
    chk("bo_wait", 64'(nw), 64'd220);
    chk("bo_grant", {39'd0, mem_en, mem_we, mem_addr, hcnt}, {39'd0, 1'b1, 1'b1, 15'h0300, 9'd320});
    cyc(); #1;
    chk("bo_ack", {54'd0, cpu_ack, hcnt}, {54'd0, 1'b1, 9'd321});
    cpu_req = 1'b0; cfg_cpu_blank_only = 1'b0;

    // CPU write then read of 0x1234
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    #1;
    chk("wr_grant", {31'd0, mem_en, mem_we, mem_addr, mem_wdata, cpu_ack},
        {31'd0, 1'b1, 1'b1, 15'h1234, 8'hA5, 1'b0});
    cyc(); #1;
    chk("wr_ack", {63'd0, cpu_ack}, 64'd1);
    cpu_req = 1'b0; #1;
    chk("wr_idle", {63'd0, mem_en}, 64'd0);
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; #1;
    chk("rd_grant", {39'd0, mem_en, mem_we, mem_wdata, mem_addr}, {39'd0, 1'b1, 1'b0, 8'h00, 15'h1234});
    cyc(); #1;
    chk("rd_ack", {55'd0, cpu_ack, cpu_rdata}, {55'd0, 1'b1, 8'hA5});
    cpu_req = 1'b0;

    // Renderer read after CPU write sees the written data
    cyc();
    ren_req = 1'b1; ren_addr = 15'h1234; #1;
    chk("raw_issue", {47'd0, mem_en, mem_we, mem_addr}, {47'd0, 1'b1, 1'b0, 15'h1234});
    cyc();
    ren_req = 1'b0; #1;
    chk("raw_data", {55'd0, ren_rvalid, ren_rdata}, {55'd0, 1'b1, 8'hA5});

    // 50-cycle renderer burst starves a held CPU read
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
    nval = 0;
    for (int k = 0; k < 50; k++) begin
      ren_req = 1'b1; ren_addr = 15'(k); #1;
      chk("burst_issue", {46'd0, mem_en, mem_we, cpu_ack, mem_addr},
          {46'd0, 1'b1, 1'b0, 1'b0, 15'(k)});
      chk("burst_rv", {55'd0, ren_rvalid, ren_rdata},
          {55'd0, k > 0, (k > 0) ? (8'(k - 1) ^ 8'h3C) : 8'h00});
      if (ren_rvalid) nval++;
      cyc();
    end
    ren_req = 1'b0; #1;
    chk("burst_last", {55'd0, ren_rvalid, ren_rdata}, {55'd0, 1'b1, 8'(49) ^ 8'h3C});
    if (ren_rvalid) nval++;
    chk("burst_count", 64'(nval), 64'd50);
    chk("burst_cpu_grant", {47'd0, mem_en, mem_we, mem_addr}, {47'd0, 1'b1, 1'b0, 15'h1234});
    cyc(); #1;
    chk("burst_cpu_ack", {54'd0, cpu_ack, ren_rvalid, cpu_rdata}, {54'd0, 1'b1, 1'b0, 8'hA5});
    cpu_req = 1'b0;

    // Continuous CPU requests: grant every other cycle
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0200; cpu_wdata = 8'h11;
    prev_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("cc_pattern", {62'd0, mem_en, cpu_ack}, {62'd0, ~k[0], k[0]});
      chk("cc_consec", {63'd0, cpu_ack & prev_ack}, 64'd0);
      prev_ack = cpu_ack;
      cyc();
    end
    cpu_req = 1'b0;

    // Reset in the ack cycle of a CPU read
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234; #1;
    chk("rst_grant", {63'd0, mem_en}, 64'd1);
    cyc();
    rst = 1'b1; #1;
    chk("rst_no_ack", {62'd0, cpu_ack, mem_en}, 64'd0);
    cpu_req = 1'b0;
    cyc(); #1;
    chk("rst_outs", all_outs(), 64'd0);
    rst = 1'b0;
    cyc(); #1;
    chk("rst_restart", {44'd0, hcnt, vcnt, cpu_ack, ren_rvalid}, {44'd0, 9'd1, 9'd0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("rst_quiet", {62'd0, cpu_ack, ren_rvalid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
